// File: rtl/tetris_pkg.sv
// Shared board constants, row-command encodings and sequencer state type.
package tetris_pkg;

   localparam int ROWS_DEF = 20;
   localparam int COLS_DEF = 10;

   // Broadcast commands understood by every row of the row array
   localparam logic [1:0] ROW_CHECK = 2'b00;
   localparam logic [1:0] ROW_MOVE  = 2'b01;
   localparam logic [1:0] ROW_WRITE = 2'b10;
   localparam logic [1:0] ROW_SHIFT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_CHECK,
      ST_SCAN,
      ST_SHIFT,
      ST_DONE
   } seq_state_t;

   // Width of a row index; a single-row board still gets a 1-bit index
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bottom_row_finder.sv
// Combinational search for the highest set bit of a row mask (the
// bottom-most flagged row, since row 0 is the top of the board).
module bottom_row_finder
   import tetris_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int IDX_W = idx_width(ROWS)
) (
   input  logic [ROWS-1:0]  mask,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Later (higher) set bits overwrite earlier ones, leaving the highest
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         if (mask[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/line_clear_seq.sv
// Line-clear sequencer: after a piece lands it writes the piece, asks
// the rows for their full flags, then collapses full rows one at a time
// from the bottom up while counting cleared lines.
module line_clear_seq
   import tetris_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ROWS-1:0]  row_full,
   output logic [1:0]       row_state,
   output logic [ROWS-1:0]  shift_row,
   output logic             busy,
   output logic             done,
   output logic [4:0]       lines_cleared,
   output logic [CNT_W-1:0] total_lines
);

   localparam int IDX_W = idx_width(ROWS);

   seq_state_t       state;
   logic [ROWS-1:0]  pending;
   logic [ROWS-1:0]  pending_nxt;
   logic [ROWS-1:0]  shift_mask;
   logic [IDX_W-1:0] bottom_idx;
   logic             bottom_vld;

   // Running total holds at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   bottom_row_finder #(
      .ROWS  (ROWS),
      .IDX_W (IDX_W)
   ) u_finder (
      .mask  (pending),
      .idx   (bottom_idx),
      .valid (bottom_vld)
   );

   // Rows at or above the bottom-most full row r shift down by one; the
   // pending flags follow the same move so a full row above r keeps
   // tracking its new position, and rows below r are untouched.
   always_comb begin
      shift_mask  = '0;
      pending_nxt = pending;
      if (bottom_vld) begin
         shift_mask[0]  = 1'b1;
         pending_nxt[0] = 1'b0;
      end
      for (int i = 1; i < ROWS; i++) begin
         if (bottom_vld && (i <= int'(bottom_idx))) begin
            shift_mask[i]  = 1'b1;
            pending_nxt[i] = pending[i-1];
         end
      end
   end

   // Shift enables are only meaningful while the shift command is broadcast
   always_comb begin
      shift_row = '0;
      if (state == ST_SHIFT) shift_row = shift_mask;
   end

   // Sequencer FSM with registered command, busy and done outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pending       <= '0;
         lines_cleared <= '0;
         total_lines   <= '0;
         row_state     <= ROW_MOVE;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_WRITE;
                  row_state <= ROW_WRITE;
                  busy      <= 1'b1;
               end
            end
            ST_WRITE: begin
               state         <= ST_CHECK;
               row_state     <= ROW_CHECK;
               lines_cleared <= '0;
            end
            ST_CHECK: begin
               state     <= ST_SCAN;
               row_state <= ROW_MOVE;
            end
            ST_SCAN: begin
               pending <= row_full;
               if (|row_full) begin
                  state     <= ST_SHIFT;
                  row_state <= ROW_SHIFT;
               end else begin
                  state     <= ST_DONE;
                  row_state <= ROW_MOVE;
                  done      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               pending       <= pending_nxt;
               lines_cleared <= lines_cleared + 5'd1;
               total_lines   <= sat_inc(total_lines);
               if (pending_nxt == '0) begin
                  state     <= ST_DONE;
                  row_state <= ROW_MOVE;
                  done      <= 1'b1;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               row_state <= ROW_MOVE;
               busy      <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               row_state <= ROW_MOVE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_seq.sv
// Testbench for line_clear_seq: table of landing patterns driven through a
// cycle-by-cycle scoreboard, plus hand sequences for reset and saturation.
module tb_line_clear_seq;

   localparam int ROWS  = 20;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [ROWS-1:0]  row_full;
   logic [1:0]       row_state;
   logic [ROWS-1:0]  shift_row;
   logic             busy;
   logic             done;
   logic [4:0]       lines_cleared;
   logic [CNT_W-1:0] total_lines;

   line_clear_seq #(
      .ROWS  (ROWS),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .row_full      (row_full),
      .row_state     (row_state),
      .shift_row     (shift_row),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .total_lines   (total_lines)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      rs;
      logic [ROWS-1:0] sr;
      logic            busy;
      logic            done;
   } obs_t;

   typedef struct {
      logic [ROWS-1:0] full;
      logic [4:0]      exp_lines;
      bit              hold_start;
   } vec_t;

   obs_t            exp_q[$];
   logic [ROWS-1:0] seen_masks[$];
   int              checks;
   int              errors;
   int              tot_model;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference model: full rows are tracked as a set of indices. Each shift
   // removes the bottom-most one and moves every row above it down by one.
   task automatic push_expected(input logic [ROWS-1:0] full, output int n);
      int              rows[$];
      int              nxt[$];
      int              r;
      logic [ROWS-1:0] m;
      n = 0;
      exp_q.push_back('{2'b10, {ROWS{1'b0}}, 1'b1, 1'b0});
      exp_q.push_back('{2'b00, {ROWS{1'b0}}, 1'b1, 1'b0});
      exp_q.push_back('{2'b01, {ROWS{1'b0}}, 1'b1, 1'b0});
      for (int k = 0; k < ROWS; k++) if (full[k]) rows.push_back(k);
      while (rows.size() > 0) begin
         r = -1;
         foreach (rows[k]) if (rows[k] > r) r = rows[k];
         m = '0;
         for (int k = 0; k <= r; k++) m[k] = 1'b1;
         exp_q.push_back('{2'b11, m, 1'b1, 1'b0});
         nxt.delete();
         foreach (rows[k]) if (rows[k] != r) nxt.push_back(rows[k] + 1);
         rows = nxt;
         n++;
      end
      exp_q.push_back('{2'b01, {ROWS{1'b0}}, 1'b1, 1'b1});
      exp_q.push_back('{2'b01, {ROWS{1'b0}}, 1'b0, 1'b0});
   endtask

   task automatic run_seq(input logic [ROWS-1:0] full, input logic [4:0] exp_lines,
                          input bit hold);
      int   n;
      obs_t e;
      obs_t a;
      seen_masks.delete();
      push_expected(full, n);
      @(negedge clk);
      row_full = full;
      start    = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         e = exp_q.pop_front();
         a = {row_state, shift_row, busy, done};
         if (a.rs == 2'b11) seen_masks.push_back(a.sr);
         check("seq_cycle", 32'(a), 32'(e));
         if (e.done) begin
            start     = 1'b0;
            tot_model = tot_model + n;
            if (tot_model > (1 << CNT_W) - 1) tot_model = (1 << CNT_W) - 1;
            check("lines_cleared", 32'(lines_cleared), 32'(exp_lines));
            check("total_lines", 32'(total_lines), 32'(tot_model));
         end
      end
   endtask

   vec_t vecs[5];

   initial begin
      checks    = 0;
      errors    = 0;
      tot_model = 0;
      reset     = 1'b1;
      start     = 1'b0;
      row_full  = '0;

      vecs[0] = '{20'h00000, 5'd0,  1'b0};
      vecs[1] = '{20'h80000, 5'd1,  1'b0};
      vecs[2] = '{20'h00001, 5'd1,  1'b1};
      vecs[3] = '{20'h80001, 5'd2,  1'b0};
      vecs[4] = '{20'h55555, 5'd10, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_row_state", 32'(row_state), 32'h1);
      check("rst_shift_row", 32'(shift_row), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_lines", 32'(lines_cleared), 32'h0);
      check("rst_total", 32'(total_lines), 32'h0);
      reset = 1'b0;

      for (int v = 0; v < 5; v++) run_seq(vecs[v].full, vecs[v].exp_lines, vecs[v].hold_start);

      // Rows 17 and 19: row 17 drops to 18 after the first shift
      run_seq(20'hA0000, 5'd2, 1'b0);
      check("r17_19_nshift", 32'(seen_masks.size()), 32'd2);
      if (seen_masks.size() == 2) begin
         check("r17_19_mask0", 32'(seen_masks[0]), 32'hFFFFF);
         check("r17_19_mask1", 32'(seen_masks[1]), 32'h7FFFF);
      end

      // Rows 16..19: four shifts, all at the bottom row
      run_seq(20'hF0000, 5'd4, 1'b0);
      check("r16_19_nshift", 32'(seen_masks.size()), 32'd4);
      foreach (seen_masks[k]) check("r16_19_mask", 32'(seen_masks[k]), 32'hFFFFF);

      // Reset during the second SHIFT cycle
      @(negedge clk);
      row_full = 20'hF0000;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_shift1", 32'(row_state), 32'h3);
      @(negedge clk);
      check("abort_shift2", 32'(row_state), 32'h3);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      tot_model = 0;
      check("abort_row_state", 32'(row_state), 32'h1);
      check("abort_shift_row", 32'(shift_row), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_total", 32'(total_lines), 32'h0);
      check("abort_lines", 32'(lines_cleared), 32'h0);
      @(negedge clk);
      check("abort_stays_idle", 32'({busy, row_state}), 32'h1);

      // Start coinciding with reset is dropped
      start = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      check("start_vs_reset", 32'({busy, row_state}), 32'h1);
      @(negedge clk);
      check("start_vs_reset2", 32'({busy, row_state}), 32'h1);

      // Fill the 8-bit total with 20-line clears until it saturates
      for (int s = 0; s < 14; s++) run_seq(20'hFFFFF, 5'd20, 1'b0);
      check("sat_total", 32'(total_lines), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
